// File: rtl/group_project_top.sv
// Branch-prediction demo top: 2-stage core running a fixed ROM loop, direct-mapped BTB,
// saturating performance counters and a UART that reports them once the program halts.
module group_project_top #(
   parameter int CLKS_PER_BIT = 434,
   parameter int BTB_ENTRIES  = 8
) (
   input  logic        CLOCK_50,
   input  logic        RST_n,
   input  logic [9:0]  SW,
   inout  wire  [35:0] GPIO
);
   localparam int IDX_W  = $clog2(BTB_ENTRIES);
   localparam int TAG_W  = 8 - IDX_W;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_DONE} uart_state_t;

   logic clk, rst;
   assign clk = CLOCK_50;
   assign rst = RST_n;

   function automatic logic [15:0] rom(input logic [7:0] addr);
      case (addr)
         8'd0:    rom = 16'hC00A;
         8'd1:    rom = 16'h0000;
         8'd2:    rom = 16'h8001;
         default: rom = 16'h2000;
      endcase
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [7:0]       pc_p0, pred_p0;
   logic [15:0]      instr_p0;
   logic [IDX_W-1:0] idx_p0, idx_p1;
   logic             hit_p0;
   logic [15:0]      instr_p1;
   logic [7:0]       pc_p1, pred_p1, actual_p1, imm_p1, r_dec, r_q;
   logic [1:0]       op_p1;
   logic             vld_p1, is_halt, is_bnz, is_br, is_ldi, taken, mispred, btb_clr, advance;
   logic             halted;
   logic [15:0]      cyc_cnt, ret_cnt, mis_cnt;

   logic [BTB_ENTRIES-1:0] btb_valid;
   logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
   logic [7:0]             btb_tgt [BTB_ENTRIES];

   // ---- F stage: ROM read and BTB lookup ----
   assign instr_p0 = rom(pc_p0);
   assign idx_p0   = pc_p0[IDX_W-1:0];
   assign hit_p0   = btb_valid[idx_p0] && (btb_tag[idx_p0] == pc_p0[7:IDX_W]) && SW[0];
   assign pred_p0  = hit_p0 ? btb_tgt[idx_p0] : pc_p0 + 8'd1;

   // ---- E stage: resolve branch, detect mispredict ----
   assign op_p1     = instr_p1[15:14];
   assign imm_p1    = instr_p1[7:0];
   assign idx_p1    = pc_p1[IDX_W-1:0];
   assign r_dec     = r_q - 8'd1;
   assign is_halt   = vld_p1 && (op_p1 == 2'b00) && instr_p1[13];
   assign is_br     = vld_p1 && (op_p1 == 2'b01);
   assign is_bnz    = vld_p1 && (op_p1 == 2'b10);
   assign is_ldi    = vld_p1 && (op_p1 == 2'b11);
   assign taken     = is_br || (is_bnz && (r_dec != 8'd0));
   assign actual_p1 = taken ? imm_p1 : pc_p1 + 8'd1;
   assign mispred   = vld_p1 && !is_halt && (actual_p1 != pred_p1);
   assign btb_clr   = is_bnz && !taken && btb_valid[idx_p1] && (btb_tag[idx_p1] == pc_p1[7:IDX_W]);
   assign advance   = !halted && !is_halt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_p0     <= 8'd0;
         vld_p1    <= 1'b0;
         r_q       <= 8'd0;
         btb_valid <= '0;
         halted    <= 1'b0;
         cyc_cnt   <= 16'd0;
         ret_cnt   <= 16'd0;
         mis_cnt   <= 16'd0;
      end else if (!halted) begin
         cyc_cnt <= sat_inc(cyc_cnt);
         if (vld_p1)  ret_cnt <= sat_inc(ret_cnt);
         if (mispred) mis_cnt <= sat_inc(mis_cnt);
         if (is_halt) begin
            halted <= 1'b1;
         end else begin
            pc_p0  <= mispred ? actual_p1 : pred_p0;
            vld_p1 <= !mispred;
            if (is_ldi)      r_q <= imm_p1;
            else if (is_bnz) r_q <= r_dec;
            if (taken)        btb_valid[idx_p1] <= 1'b1;
            else if (btb_clr) btb_valid[idx_p1] <= 1'b0;
         end
      end
   end

   // Data side of the pipe and BTB payload carry no reset; vld_p1/btb_valid qualify them.
   always_ff @(posedge clk) begin
      if (advance) begin
         instr_p1 <= instr_p0;
         pc_p1    <= pc_p0;
         pred_p1  <= pred_p0;
      end
      if (advance && taken) begin
         btb_tag[idx_p1] <= pc_p1[7:IDX_W];
         btb_tgt[idx_p1] <= actual_p1;
      end
   end

   // ---- UART report: mispredicts then cycles, MSB byte first ----
   uart_state_t      u_state, u_next;
   logic [BAUD_W-1:0] baud;
   logic [2:0]       bit_idx;
   logic [1:0]       byte_idx;
   logic [7:0]       tx_byte;
   logic             bit_done, tx;

   assign bit_done = (baud == BAUD_LAST);

   always_comb begin
      case (byte_idx)
         2'd0:    tx_byte = mis_cnt[15:8];
         2'd1:    tx_byte = mis_cnt[7:0];
         2'd2:    tx_byte = cyc_cnt[15:8];
         default: tx_byte = cyc_cnt[7:0];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) u_state <= U_IDLE;
      else     u_state <= u_next;
   end

   always_comb begin
      u_next = u_state;
      tx     = 1'b1;
      case (u_state)
         U_IDLE:  if (halted) u_next = U_START;
         U_START: begin
            tx = 1'b0;
            if (bit_done) u_next = U_DATA;
         end
         U_DATA: begin
            tx = tx_byte[bit_idx];
            if (bit_done && bit_idx == 3'd7) u_next = U_STOP;
         end
         U_STOP:  if (bit_done) u_next = (byte_idx == 2'd3) ? U_DONE : U_START;
         default: u_next = U_DONE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud     <= '0;
         bit_idx  <= 3'd0;
         byte_idx <= 2'd0;
      end else begin
         if (u_state == U_IDLE || u_state == U_DONE || bit_done) baud <= '0;
         else                                                     baud <= baud + 1'b1;
         if (u_state == U_DATA && bit_done) bit_idx  <= bit_idx + 3'd1;
         if (u_state == U_STOP && bit_done) byte_idx <= byte_idx + 2'd1;
      end
   end

   assign GPIO = {{32{1'bz}}, tx, {3{1'bz}}};

   logic unused_bits;
   assign unused_bits = ^{SW[9:1], instr_p1[12:8], ret_cnt};
endmodule

// File: tb/tb_group_project_top.sv
// Bench for group_project_top: runs the ROM program under several SW[0] schedules and
// decodes the UART report, comparing against an instruction-level predictor model.
module tb_group_project_top;
   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  sw  = '0;
   wire  [35:0] gpio;
   int          errors = 0;
   int          checks = 0;
   bit          sched [1:300];

   group_project_top #(.CLKS_PER_BIT(CPB), .BTB_ENTRIES(8)) dut (
      .CLOCK_50(clk), .RST_n(rst), .SW(sw), .GPIO(gpio)
   );

   always #5 clk = ~clk;

   // Executes the program one instruction at a time; each fetch costs one cycle and a
   // mispredict costs one extra. BTB writes become visible the cycle after execution.
   function automatic void model(output int mis, output int cyc, output int ret);
      int pc = 0, r = 0, f = 1;
      bit v [8];
      int tg [8], tt [8];
      bit pend = 0, pend_tk = 0, prev_miss = 0;
      int p_idx = 0, p_tag = 0, p_tgt = 0;
      mis = 0; cyc = 0; ret = 0;
      for (int i = 0; i < 8; i++) begin v[i] = 0; tg[i] = 0; tt[i] = 0; end
      for (int k = 0; k < 500; k++) begin
         int kind, arg, pred, actual, idx;
         bit taken, hit, isbr;
         if (prev_miss && pend) begin
            if (pend_tk) begin v[p_idx] = 1; tg[p_idx] = p_tag; tt[p_idx] = p_tgt; end
            else if (v[p_idx] && tg[p_idx] == p_tag) v[p_idx] = 0;
            pend = 0;
         end
         idx  = pc % 8;
         hit  = sched[f] && v[idx] && (tg[idx] == pc / 8);
         pred = hit ? tt[idx] : (pc + 1) % 256;
         if (pend) begin
            if (pend_tk) begin v[p_idx] = 1; tg[p_idx] = p_tag; tt[p_idx] = p_tgt; end
            else if (v[p_idx] && tg[p_idx] == p_tag) v[p_idx] = 0;
            pend = 0;
         end
         case (pc)
            0:       begin kind = 3; arg = 10; end
            1:       begin kind = 0; arg = 0;  end
            2:       begin kind = 2; arg = 1;  end
            default: begin kind = 4; arg = 0;  end
         endcase
         ret++;
         if (kind == 4) begin cyc = f + 1; return; end
         taken = 0; isbr = 0;
         if (kind == 3) r = arg;
         else if (kind == 2) begin r = (r + 255) % 256; isbr = 1; taken = (r != 0); end
         actual = taken ? arg : (pc + 1) % 256;
         if (isbr) begin pend = 1; pend_tk = taken; p_idx = idx; p_tag = pc / 8; p_tgt = actual; end
         prev_miss = (actual != pred);
         if (prev_miss) mis++;
         pc = actual;
         f += prev_miss ? 2 : 1;
      end
   endfunction

   task automatic release_and_drive();
      @(negedge clk);
      rst   = 1'b0;
      sw[0] = sched[1];
      fork
         begin
            for (int t = 2; t <= 200; t++) begin
               @(negedge clk);
               if (rst) break;
               sw[0] = sched[t];
            end
         end
      join_none
   endtask

   task automatic uart_recv(output logic [31:0] data, output bit timeout, output int ferr);
      int n = 0;
      logic [7:0] by;
      data = '0; timeout = 0; ferr = 0; by = '0;
      do begin @(negedge clk); n++; end while (gpio[3] !== 1'b0 && n < 3000);
      if (gpio[3] !== 1'b0) begin timeout = 1; return; end
      for (int b = 0; b < 4; b++) begin
         if (b > 0 && gpio[3] !== 1'b0) ferr++;
         repeat (CPB - 1) @(negedge clk);
         if (gpio[3] !== 1'b0) ferr++;
         repeat (CPB / 2 + 1) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            by[i] = gpio[3];
            if (i < 7) repeat (CPB) @(negedge clk);
         end
         repeat (CPB) @(negedge clk);
         if (gpio[3] !== 1'b1) ferr++;
         repeat (CPB - CPB / 2) @(negedge clk);
         data = {data[23:0], by};
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; sw = '0;
      repeat (3) @(negedge clk);
      checks++; if (gpio[3] !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", gpio[3]); end
      checks++; if (dut.pc_p0 !== 8'd0) begin errors++; $display("FAIL reset_pc got=%0d exp=0", dut.pc_p0); end
      checks++; if (dut.vld_p1 !== 1'b0) begin errors++; $display("FAIL reset_bubble got=%b exp=0", dut.vld_p1); end
      checks++; if (dut.r_q !== 8'd0) begin errors++; $display("FAIL reset_r got=%0d exp=0", dut.r_q); end
      checks++; if (dut.btb_valid !== 8'h00) begin errors++; $display("FAIL reset_btb got=%h exp=00", dut.btb_valid); end
      checks++; if (dut.cyc_cnt !== 16'd0) begin errors++; $display("FAIL reset_cycles got=%0d exp=0", dut.cyc_cnt); end
      checks++; if (dut.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", dut.halted); end
   endtask

   task automatic test_no_btb();
      logic [31:0] d; bit to; int fe;
      for (int i = 1; i <= 300; i++) sched[i] = 1'b0;
      rst = 1'b1; repeat (2) @(negedge clk);
      release_and_drive();
      uart_recv(d, to, fe);
      checks++; if (to) begin errors++; $display("FAIL nobtb_timeout got=timeout exp=frame"); end
      checks++; if (fe !== 0) begin errors++; $display("FAIL nobtb_framing got=%0d exp=0", fe); end
      checks++; if (d !== 32'h0009_0020) begin errors++; $display("FAIL nobtb_report got=%h exp=00090020", d); end
      checks++; if (dut.ret_cnt !== 16'd22) begin errors++; $display("FAIL nobtb_retired got=%0d exp=22", dut.ret_cnt); end
   endtask

   task automatic test_btb();
      logic [31:0] d; bit to; int fe;
      for (int i = 1; i <= 300; i++) sched[i] = 1'b1;
      rst = 1'b1; repeat (2) @(negedge clk);
      release_and_drive();
      uart_recv(d, to, fe);
      checks++; if (to) begin errors++; $display("FAIL btb_timeout got=timeout exp=frame"); end
      checks++; if (fe !== 0) begin errors++; $display("FAIL btb_framing got=%0d exp=0", fe); end
      checks++; if (d !== 32'h0002_0019) begin errors++; $display("FAIL btb_report got=%h exp=00020019", d); end
      checks++; if (dut.ret_cnt !== 16'd22) begin errors++; $display("FAIL btb_retired got=%0d exp=22", dut.ret_cnt); end
   endtask

   task automatic test_after_halt();
      int bad = 0;
      checks++; if (dut.btb_valid[2] !== 1'b0) begin errors++; $display("FAIL halt_btb2_valid got=%b exp=0", dut.btb_valid[2]); end
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (gpio[3] !== 1'b1 || dut.cyc_cnt !== 16'd25) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL halt_frozen_idle got=%0d bad cycles exp=0", bad); end
      checks++; if (dut.cyc_cnt !== 16'd25) begin errors++; $display("FAIL halt_cycles got=%0d exp=25", dut.cyc_cnt); end
   endtask

   task automatic test_reset_mid_tx();
      logic [31:0] d; bit to; int fe; int n = 0;
      for (int i = 1; i <= 300; i++) sched[i] = 1'b0;
      rst = 1'b1; repeat (2) @(negedge clk);
      release_and_drive();
      do begin @(negedge clk); n++; end while (gpio[3] !== 1'b0 && n < 3000);
      checks++;
      if (gpio[3] !== 1'b0) begin
         errors++; $display("FAIL abort_timeout got=%b exp=0", gpio[3]);
      end else begin
         repeat (10 * CPB + 2 * CPB + CPB / 2) @(negedge clk);
         checks++; if (gpio[3] !== 1'b0) begin errors++; $display("FAIL abort_pre_tx got=%b exp=0", gpio[3]); end
         #2 rst = 1'b1;
         #1;
         checks++; if (gpio[3] !== 1'b1) begin errors++; $display("FAIL abort_tx_now got=%b exp=1", gpio[3]); end
      end
      repeat (2) @(negedge clk);
      release_and_drive();
      uart_recv(d, to, fe);
      checks++; if (to || fe !== 0) begin errors++; $display("FAIL abort_resend_frame got=to%0d/fe%0d exp=0/0", to, fe); end
      checks++; if (d !== 32'h0009_0020) begin errors++; $display("FAIL abort_resend got=%h exp=00090020", d); end
   endtask

   task automatic test_sw_gap();
      logic [31:0] d; bit to; int fe, em, ec, er;
      for (int i = 1; i <= 300; i++) sched[i] = (i >= 5 && i <= 10) ? 1'b0 : 1'b1;
      model(em, ec, er);
      rst = 1'b1; repeat (2) @(negedge clk);
      release_and_drive();
      uart_recv(d, to, fe);
      checks++; if (to || fe !== 0) begin errors++; $display("FAIL gap_frame got=to%0d/fe%0d exp=0/0", to, fe); end
      checks++; if (d !== {16'(em), 16'(ec)}) begin errors++; $display("FAIL gap_report got=%h exp=%h", d, {16'(em), 16'(ec)}); end
      checks++; if (d[31:16] < 16'd2 || d[31:16] > 16'd9) begin errors++; $display("FAIL gap_mis_range got=%0d exp=2..9", d[31:16]); end
      checks++; if (d[15:0] !== 16'(er + 1) + d[31:16]) begin errors++; $display("FAIL gap_identity got=%0d exp=%0d", d[15:0], er + 1 + d[31:16]); end
      checks++; if (dut.ret_cnt !== 16'(er)) begin errors++; $display("FAIL gap_retired got=%0d exp=%0d", dut.ret_cnt, er); end
   endtask

   task automatic test_random_sw();
      logic [31:0] d; bit to; int fe, em, ec, er;
      for (int it = 0; it < 3; it++) begin
         for (int i = 1; i <= 300; i++) sched[i] = 1'($urandom_range(1, 0));
         model(em, ec, er);
         rst = 1'b1; repeat (2) @(negedge clk);
         release_and_drive();
         uart_recv(d, to, fe);
         checks++; if (to || fe !== 0) begin errors++; $display("FAIL rand%0d_frame got=to%0d/fe%0d exp=0/0", it, to, fe); end
         checks++; if (d !== {16'(em), 16'(ec)}) begin errors++; $display("FAIL rand%0d_report got=%h exp=%h", it, d, {16'(em), 16'(ec)}); end
         checks++; if (dut.ret_cnt !== 16'(er)) begin errors++; $display("FAIL rand%0d_retired got=%0d exp=%0d", it, dut.ret_cnt, er); end
      end
   endtask

   initial begin
      test_reset();
      test_no_btb();
      test_btb();
      test_after_halt();
      test_reset_mid_tx();
      test_sw_gap();
      test_random_sw();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
